alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: operation request valid.
REQ-004 SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-005 SHALL have port req_op, input, 3 bits: ALU select code.
REQ-006 SHALL have ports req_a and req_b, inputs, 4 bits each: operands.
REQ-007 SHALL have port req_acc, input, 1 bit: 1 means use the accumulator as operand A instead of req_a.
REQ-008 SHALL have ports alu_a and alu_b (output, 4 bits each), alu_s (output, 3 bits) and alu_cin (output, 1 bit): registered drive to the external ALU.
REQ-009 SHALL have ports alu_f (input, 4 bits) and alu_cout (input, 1 bit): combinational ALU result.
REQ-010 SHALL have ports rsp_valid (output, 1 bit), rsp_ready (input, 1 bit), rsp_f (output, 4 bits), rsp_cout (output, 1 bit) and rsp_err (output, 1 bit): response channel.
REQ-011 SHALL have port acc, output, 4 bits: accumulator value.

Function
REQ-012 SHALL implement the FSM states IDLE, EXEC and RESP; req_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: when req_valid=1, SHALL register alu_a (acc if req_acc=1, else req_a), alu_b=req_b and alu_s=req_op, then go to EXEC.
REQ-014 alu_cin SHALL be 1 when req_op=010 and 0 for every other op.
REQ-015 EXEC: lasts exactly 1 cycle; at its closing edge SHALL capture rsp_f=alu_f and rsp_cout=alu_cout, then go to RESP.
REQ-016 Timing: request accepted at edge N gives rsp_valid=1 from cycle N+2.
REQ-017 RESP: rsp_valid=1; rsp_f, rsp_cout and rsp_err SHALL hold stable until rsp_ready=1, then go to IDLE on that edge.
REQ-018 Minimum spacing between accepted requests is 3 cycles; no overlap and no request queue.
REQ-019 acc SHALL be loaded with alu_f at the EXEC capture edge for legal ops only.
REQ-020 Illegal op 111: SHALL still be accepted; capture rsp_f=0000, rsp_cout=0, rsp_err=1; acc unchanged.
REQ-021 rsp_err SHALL be 0 for ops 000-110.
REQ-022 alu_* outputs SHALL hold their last values outside EXEC.
REQ-023 req_valid while req_ready=0 SHALL be ignored; it is not latched.

Reset
REQ-024 When rst=1 at a clock edge, SHALL force state IDLE and clear acc, alu_a, alu_b, alu_s, alu_cin, rsp_f, rsp_cout, rsp_err and rsp_valid to 0.
REQ-025 rst SHALL take priority over every other event; an in-flight operation is discarded and produces no response.
REQ-026 In the first cycle after reset is released, req_ready SHALL be 1.

Configuration
REQ-027 Macro ALU_CTRL_FLAGS_EN.
REQ-028 With ALU_CTRL_FLAGS_EN defined: SHALL add outputs rsp_zero (rsp_f==0000) and rsp_ovf (signed overflow).
REQ-029 Overflow rules: op 001 when A[3]==B[3] and F[3]!=A[3]; op 010 when A[3]!=B[3] and F[3]!=A[3]; 0 for all other ops. Both flags are captured alongside rsp_f and reset to 0.
REQ-030 Without ALU_CTRL_FLAGS_EN: the flag ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Add: op=001, a=0111, b=0011 -> rsp_f=1010, rsp_cout=0, rsp_valid=1 two cycles after accept; with flags, rsp_ovf=1.
REQ-032 Subtract: op=010, a=0101, b=0011 -> alu_cin=1, rsp_f=0010, rsp_cout=1, acc=0010.
REQ-033 Accumulate: run the subtract above, then op=001, req_acc=1, b=0001 -> alu_a=0010, rsp_f=0011, acc=0011.
REQ-034 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_f and rsp_valid stable, req_ready=0, a second req_valid is ignored.
REQ-035 Illegal op: op=111 -> rsp_err=1, rsp_f=0000, acc unchanged.
REQ-036 Reset mid-op: assert rst during EXEC -> next cycle rsp_valid=0, acc=0000, req_ready=1, no response produced.

Source files
------------

// File: rtl/alu_ctrl.sv
// Sequencer for an external combinational 4-bit ALU: accepts one request at a time,
// drives the ALU, captures its result into an accumulator and response channel.
// Optional ALU_CTRL_FLAGS_EN adds zero and signed-overflow response flags.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic       req_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_s,
  output logic       alu_cin,
  input  logic [3:0] alu_f,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_f,
  output logic       rsp_cout,
  output logic       rsp_err,
  output logic [3:0] acc
`ifdef ALU_CTRL_FLAGS_EN
  ,
  output logic       rsp_zero,
  output logic       rsp_ovf
`endif
);

  localparam logic [2:0] OpAdd     = 3'b001;
  localparam logic [2:0] OpSub     = 3'b010;
  localparam logic [2:0] OpIllegal = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state;
  logic   illegal;

  assign req_ready = (state == StIdle);
  assign illegal   = (alu_s == OpIllegal);

`ifdef ALU_CTRL_FLAGS_EN
  logic ovf_next;

  // Signed overflow of the add/subtract the ALU is performing right now.
  always_comb begin
    ovf_next = 1'b0;
    if (alu_s == OpAdd) begin
      ovf_next = (alu_a[3] == alu_b[3]) && (alu_f[3] != alu_a[3]);
    end else if (alu_s == OpSub) begin
      ovf_next = (alu_a[3] != alu_b[3]) && (alu_f[3] != alu_a[3]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= 4'b0000;
      alu_a     <= 4'b0000;
      alu_b     <= 4'b0000;
      alu_s     <= 3'b000;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_f     <= 4'b0000;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            alu_a   <= req_acc ? acc : req_a;
            alu_b   <= req_b;
            alu_s   <= req_op;
            alu_cin <= (req_op == OpSub);
            state   <= StExec;
          end
        end
        StExec: begin
          rsp_valid <= 1'b1;
          state     <= StResp;
          if (illegal) begin
            rsp_f    <= 4'b0000;
            rsp_cout <= 1'b0;
            rsp_err  <= 1'b1;
`ifdef ALU_CTRL_FLAGS_EN
            rsp_zero <= 1'b1;
            rsp_ovf  <= 1'b0;
`endif
          end else begin
            rsp_f    <= alu_f;
            rsp_cout <= alu_cout;
            rsp_err  <= 1'b0;
            acc      <= alu_f;
`ifdef ALU_CTRL_FLAGS_EN
            rsp_zero <= (alu_f == 4'b0000);
            rsp_ovf  <= ovf_next;
`endif
          end
        end
        StResp: begin
          // Response fields stay frozen until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural 4-bit ALU attached to its drive ports.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic       alu_cin;
  logic [3:0] alu_f;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_f;
  logic       rsp_cout;
  logic       rsp_err;
  logic [3:0] acc;
`ifdef ALU_CTRL_FLAGS_EN
  logic       rsp_zero;
  logic       rsp_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_acc   (req_acc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_cin   (alu_cin),
    .alu_f     (alu_f),
    .alu_cout  (alu_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err),
    .acc       (acc)
`ifdef ALU_CTRL_FLAGS_EN
    ,
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf)
`endif
  );

  // External ALU: 000 and, 001 add, 010 a+~b+cin, 011 or, 100 xor, 101 not a, 110 pass b.
  always_comb begin
    logic [4:0] sum;
    sum      = 5'd0;
    alu_f    = 4'hF;
    alu_cout = 1'b1;
    case (alu_s)
      3'b000: begin alu_f = alu_a & alu_b; alu_cout = 1'b0; end
      3'b001: begin sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
                    alu_f = sum[3:0]; alu_cout = sum[4]; end
      3'b010: begin sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
                    alu_f = sum[3:0]; alu_cout = sum[4]; end
      3'b011: begin alu_f = alu_a | alu_b; alu_cout = 1'b0; end
      3'b100: begin alu_f = alu_a ^ alu_b; alu_cout = 1'b0; end
      3'b101: begin alu_f = ~alu_a; alu_cout = 1'b0; end
      3'b110: begin alu_f = alu_b; alu_cout = 1'b0; end
      default: begin alu_f = 4'hF; alu_cout = 1'b1; end
    endcase
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
    logic [3:0] f;
    logic       cout;
    logic       err;
    logic [3:0] acc;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  // Issue one request from IDLE and check EXEC drive and RESP capture, then release it.
  task automatic run_op(input vec_t v, input logic [3:0] prev_acc, input string tag);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_acc   = v.use_acc;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " exec req_ready"}, {7'd0, req_ready}, 8'd0);
    check({tag, " exec rsp_valid"}, {7'd0, rsp_valid}, 8'd0);
    check({tag, " alu_a"}, {4'd0, alu_a}, {4'd0, v.use_acc ? prev_acc : v.a});
    check({tag, " alu_b"}, {4'd0, alu_b}, {4'd0, v.b});
    check({tag, " alu_s"}, {5'd0, alu_s}, {5'd0, v.op});
    check({tag, " alu_cin"}, {7'd0, alu_cin}, {7'd0, v.op == 3'b010});
    @(negedge clk);
    check({tag, " rsp_valid"}, {7'd0, rsp_valid}, 8'd1);
    check({tag, " rsp_f"}, {4'd0, rsp_f}, {4'd0, v.f});
    check({tag, " rsp_cout"}, {7'd0, rsp_cout}, {7'd0, v.cout});
    check({tag, " rsp_err"}, {7'd0, rsp_err}, {7'd0, v.err});
    check({tag, " acc"}, {4'd0, acc}, {4'd0, v.acc});
`ifdef ALU_CTRL_FLAGS_EN
    check({tag, " rsp_ovf"}, {7'd0, rsp_ovf}, {7'd0, v.ovf});
    check({tag, " rsp_zero"}, {7'd0, rsp_zero}, {7'd0, v.f == 4'd0});
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " back to idle"}, {7'd0, req_ready}, 8'd1);
    check({tag, " rsp_valid drop"}, {7'd0, rsp_valid}, 8'd0);
  endtask

  initial begin
    logic [3:0] model_acc;

    //         op      a        b        acc f        cout  err   acc      ovf
    vecs[0]  = '{3'b001, 4'b0111, 4'b0011, 0, 4'b1010, 1'b0, 1'b0, 4'b1010, 1'b1};
    vecs[1]  = '{3'b010, 4'b0101, 4'b0011, 0, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0};
    vecs[2]  = '{3'b001, 4'b1111, 4'b0001, 1, 4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0};
    vecs[3]  = '{3'b111, 4'b1111, 4'b1111, 0, 4'b0000, 1'b0, 1'b1, 4'b0011, 1'b0};
    vecs[4]  = '{3'b000, 4'b1100, 4'b1010, 0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0};
    vecs[5]  = '{3'b010, 4'b1000, 4'b0001, 0, 4'b0111, 1'b1, 1'b0, 4'b0111, 1'b1};
    vecs[6]  = '{3'b011, 4'b0100, 4'b0001, 0, 4'b0101, 1'b0, 1'b0, 4'b0101, 1'b0};
    vecs[7]  = '{3'b100, 4'b1111, 4'b0101, 0, 4'b1010, 1'b0, 1'b0, 4'b1010, 1'b0};
    vecs[8]  = '{3'b001, 4'b1001, 4'b1000, 0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1};
    vecs[9]  = '{3'b110, 4'b0110, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[10] = '{3'b101, 4'b0011, 4'b0110, 0, 4'b1100, 1'b0, 1'b0, 4'b1100, 1'b0};
    vecs[11] = '{3'b010, 4'b0000, 4'b0100, 1, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_a     = 4'd0;
    req_b     = 4'd0;
    req_acc   = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset req_ready", {7'd0, req_ready}, 8'd1);
    check("reset rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("reset acc", {4'd0, acc}, 8'd0);
    check("reset alu_a", {4'd0, alu_a}, 8'd0);
    check("reset alu_s", {5'd0, alu_s}, 8'd0);
    check("reset alu_cin", {7'd0, alu_cin}, 8'd0);
    check("reset rsp_f", {4'd0, rsp_f}, 8'd0);
    check("reset rsp_err", {7'd0, rsp_err}, 8'd0);

    model_acc = 4'd0;
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], model_acc, $sformatf("vec%0d", i));
      model_acc = vecs[i].acc;
    end

    // Backpressure: response held for 5 cycles while a second request is offered.
    run_hold : begin
      req_valid = 1'b1;
      req_op    = 3'b001;
      req_a     = 4'b0001;
      req_b     = 4'b0010;
      req_acc   = 1'b0;
      @(negedge clk);
      req_op = 3'b011;
      req_a  = 4'b1111;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
        check("bp rsp_valid", {7'd0, rsp_valid}, 8'd1);
        check("bp rsp_f", {4'd0, rsp_f}, 8'b0011);
        check("bp req_ready", {7'd0, req_ready}, 8'd0);
        check("bp alu_s held", {5'd0, alu_s}, 8'b001);
        @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp idle", {7'd0, req_ready}, 8'd1);
      @(negedge clk);
      check("bp not latched", {7'd0, req_ready}, 8'd1);
      check("bp alu_s after", {5'd0, alu_s}, 8'b001);
      check("bp acc", {4'd0, acc}, 8'b0011);
    end

    // Reset while in EXEC discards the operation.
    req_valid = 1'b1;
    req_op    = 3'b010;
    req_a     = 4'b0111;
    req_b     = 4'b0001;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst mid alu_s", {5'd0, alu_s}, 8'b010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("rst mid acc", {4'd0, acc}, 8'd0);
    check("rst mid req_ready", {7'd0, req_ready}, 8'd1);
    check("rst mid alu_a", {4'd0, alu_a}, 8'd0);
    @(negedge clk);
    check("rst mid no rsp", {7'd0, rsp_valid}, 8'd0);
    check("rst mid still idle", {7'd0, req_ready}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
